// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b LSB first through one
// full-subtractor cell, with a start/ready operand handshake and valid/ready result.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             in_ready,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bo,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic             borrow;
    logic [CW-1:0]    count;
    logic             a_msb;
    logic             b_msb;

    // Full-subtractor cell operating on the current LSBs of the operand shifters.
    logic a0;
    logic b0;
    logic d;
    logic borrow_next;
    logic last_bit;

    always_comb begin
        a0          = sa[0];
        b0          = sb[0];
        d           = a0 ^ b0 ^ borrow;
        borrow_next = (~a0 & b0) | (~(a0 ^ b0) & borrow);
        last_bit    = (count == CW'(WIDTH - 1));
    end

    // NOTE: every register here is a flop written with <=, and the synchronous
    // reset clears all of them, including the result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            diff      <= '0;
            bo        <= 1'b0;
            ovf       <= 1'b0;
            sa        <= '0;
            sb        <= '0;
            borrow    <= 1'b0;
            count     <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sa       <= a;
                        sb       <= b;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        borrow   <= 1'b0;
                        count    <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    // Difference bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
                    diff   <= {d, diff[WIDTH-1:1]};
                    sa     <= sa >> 1;
                    sb     <= sb >> 1;
                    borrow <= borrow_next;
                    count  <= count + 1'b1;
                    if (last_bit) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        bo        <= borrow_next;
                        ovf       <= (a_msb ^ b_msb) & (a_msb ^ d);
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; a new operand waits for IDLE.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random subtractions on
// WIDTH=8 and WIDTH=4 instances, checked against plain-arithmetic expectations.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic       or8    = 1'b1;
    logic [7:0] a8     = '0;
    logic [7:0] b8     = '0;
    logic       ir8, bz8, ov8, bo8, of8;
    logic [7:0] d8;

    logic       start4 = 1'b0;
    logic       or4    = 1'b1;
    logic [3:0] a4     = '0;
    logic [3:0] b4     = '0;
    logic       ir4, bz4, ov4, bo4, of4;
    logic [3:0] d4;

    int n_cmp = 0;
    int n_err = 0;
    bit sel4  = 1'b0;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .in_ready(ir8), .busy(bz8), .out_valid(ov8), .out_ready(or8),
        .diff(d8), .bo(bo8), .ovf(of8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .in_ready(ir4), .busy(bz4), .out_valid(ov4), .out_ready(or4),
        .diff(d4), .bo(bo4), .ovf(of4)
    );

    always #5 clk = ~clk;

    function automatic logic f_ir();   return sel4 ? ir4 : ir8; endfunction
    function automatic logic f_busy(); return sel4 ? bz4 : bz8; endfunction
    function automatic logic f_ov();   return sel4 ? ov4 : ov8; endfunction
    function automatic logic f_bo();   return sel4 ? bo4 : bo8; endfunction
    function automatic logic f_of();   return sel4 ? of4 : of8; endfunction
    function automatic logic [7:0] f_diff(); return sel4 ? {4'b0, d4} : d8; endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s (w%0d): observed %0h expected %0h", tag, sel4 ? 4 : 8, obs, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [7:0] av, input logic [7:0] bv);
        if (sel4) begin
            start4 = st; a4 = av[3:0]; b4 = bv[3:0];
        end else begin
            start8 = st; a8 = av; b8 = bv;
        end
    endtask

    task automatic set_ready(input logic r);
        if (sel4) or4 = r;
        else      or8 = r;
    endtask

    task automatic check_reset_state();
        check("rst_in_ready", 32'(f_ir()), 1);
        check("rst_busy", 32'(f_busy()), 0);
        check("rst_out_valid", 32'(f_ov()), 0);
        check("rst_diff", 32'(f_diff()), 0);
        check("rst_bo", 32'(f_bo()), 0);
        check("rst_ovf", 32'(f_of()), 0);
    endtask

    // One full transaction; hold = cycles of backpressure after out_valid,
    // junk = pulse start with a=b=1 during RUN, DONE and the accepting cycle.
    task automatic do_op(input bit w4, input int unsigned av_in, input int unsigned bv_in,
                         input int hold, input bit junk);
        int          w, lat, sav, sbv, r;
        int unsigned m, av, bv;
        logic [7:0]  ed;
        logic        eb, eo;
        sel4 = w4;
        w    = w4 ? 4 : 8;
        m    = (32'd1 << w) - 1;
        av   = av_in & m;
        bv   = bv_in & m;
        ed   = 8'((av - bv) & m);
        eb   = (av < bv);
        sav  = (av >= (32'd1 << (w - 1))) ? int'(av) - (1 << w) : int'(av);
        sbv  = (bv >= (32'd1 << (w - 1))) ? int'(bv) - (1 << w) : int'(bv);
        r    = sav - sbv;
        eo   = (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));

        set_ready(hold == 0);
        check("idle_in_ready", 32'(f_ir()), 1);
        drive(1'b1, 8'(av), 8'(bv));
        @(negedge clk);
        drive(1'b0, 8'($urandom), 8'($urandom));
        check("run_busy", 32'(f_busy()), 1);
        check("run_in_ready", 32'(f_ir()), 0);

        lat = 0;
        while (f_ov() !== 1'b1 && lat < w + 4) begin
            if (junk && lat == 1) drive(1'b1, 8'd1, 8'd1);
            else                  drive(1'b0, 8'($urandom), 8'($urandom));
            @(negedge clk);
            lat++;
        end
        drive(1'b0, 8'($urandom), 8'($urandom));
        check("latency", 32'(lat), 32'(w));
        check("diff", 32'(f_diff()), 32'(ed));
        check("bo", 32'(f_bo()), 32'(eb));
        check("ovf", 32'(f_of()), 32'(eo));

        for (int i = 0; i < hold; i++) begin
            if (junk && i == 0) drive(1'b1, 8'd1, 8'd1);
            @(negedge clk);
            drive(1'b0, 8'($urandom), 8'($urandom));
            check("hold_valid", 32'(f_ov()), 1);
            check("hold_diff", 32'(f_diff()), 32'(ed));
            check("hold_bo_ovf", {30'd0, f_bo(), f_of()}, {30'd0, eb, eo});
        end

        set_ready(1'b1);
        if (junk) drive(1'b1, 8'd1, 8'd1);
        @(negedge clk);
        drive(1'b0, 8'($urandom), 8'($urandom));
        check("ack_valid", 32'(f_ov()), 0);
        check("ack_in_ready", 32'(f_ir()), 1);
        check("ack_busy", 32'(f_busy()), 0);
        check("ack_diff_kept", 32'(f_diff()), 32'(ed));
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        sel4 = 1'b0;
        check_reset_state();
        sel4 = 1'b1;
        check_reset_state();
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the test plan plus range corners.
        do_op(1'b0, 200, 55, 0, 1'b0);
        do_op(1'b0, 55, 200, 0, 1'b0);
        do_op(1'b0, 32'h80, 32'h01, 0, 1'b0);
        do_op(1'b0, 0, 0, 0, 1'b0);
        do_op(1'b0, 32'h7F, 32'hFF, 0, 1'b0);
        do_op(1'b0, 255, 0, 0, 1'b0);
        do_op(1'b0, 0, 255, 0, 1'b0);
        do_op(1'b0, 100, 30, 5, 1'b1);
        do_op(1'b1, 3, 5, 0, 1'b0);
        do_op(1'b1, 4'h8, 4'h1, 2, 1'b1);

        // Reset asserted at the 4th RUN edge discards the operation.
        sel4 = 1'b0;
        set_ready(1'b1);
        drive(1'b1, 8'd77, 8'd12);
        @(negedge clk);
        drive(1'b0, 8'd0, 8'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();
        do_op(1'b0, 10, 3, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            do_op(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor computing A − B, LSB first, one bit per clock.
- Uses a single full-subtractor cell (difference/borrow) iterated over WIDTH bits.
- Serves as the arithmetic counterpart to the team's full-adder cells, for area-constrained datapaths.
- Operands are accepted on a ready/start handshake; the result is returned on a valid/ready handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to load operands; honoured only when in_ready=1.
- a  input  WIDTH  minuend, sampled on the accepting edge.
- b  input  WIDTH  subtrahend, sampled on the accepting edge.
- in_ready  output  1  high in IDLE only.
- busy  output  1  high in RUN.
- out_valid  output  1  high in DONE; result is stable while high.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  A − B modulo 2^WIDTH.
- bo  output  1  final borrow; 1 iff unsigned a < b.
- ovf  output  1  signed overflow of A − B.

Behaviour:
- Reset (rst=1 at an edge):
  - state→IDLE.
  - in_ready=1; busy=0; out_valid=0.
  - diff=0; bo=0; ovf=0.
  - Internal shift registers, borrow and counter cleared.
  - rst has priority over all other inputs in every state, including mid-RUN and mid-DONE; any partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: capture a→sa, b→sb and a[WIDTH-1], b[WIDTH-1] (for ovf); borrow←0; count←0; state→RUN.
  - start=0: remain in IDLE.
  - a and b are ignored except on the accepting edge.
- RUN, each edge:
  - a0=sa[0], b0=sb[0].
  - d = a0 ^ b0 ^ borrow.
  - borrow_next = (~a0 & b0) | (~(a0 ^ b0) & borrow).
  - d is shifted into the diff register from the MSB side; sa and sb shift right by 1; count increments.
  - On the edge processing bit WIDTH-1 (count=WIDTH-1), state→DONE. After that edge: bo=borrow_next, ovf=(a_msb ^ b_msb) & (a_msb ^ diff[WIDTH-1]), out_valid=1.
  - start is ignored in RUN.
- DONE:
  - diff, bo and ovf are held stable.
  - out_ready=1 at an edge: state→IDLE, out_valid→0. diff, bo and ovf keep their values until the next result overwrites them.
  - out_ready=0: hold in DONE indefinitely (backpressure).
  - start is ignored in DONE, including in the cycle out_ready=1; a new start is accepted only from IDLE, on the following cycle.
- Latency and throughput:
  - Start accepted at edge k → out_valid high after edge k+WIDTH.
  - Minimum spacing between accepted starts is WIDTH+2 cycles.
- diff is undefined (don't-care) during RUN; the consumer samples it only while out_valid=1.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan:
- WIDTH=8, a=200, b=55, out_ready=1 → out_valid exactly 8 cycles after the accepting edge; diff=145, bo=0, ovf=0; in_ready returns to 1 one cycle later.
- a=55, b=200 → diff=111 (0x6F), bo=1, ovf=0.
- a=0x80, b=0x01 → diff=0x7F, bo=0, ovf=1. Also a=0, b=0 → diff=0, bo=0, ovf=0.
- Backpressure and start-while-busy:
  - Hold out_ready=0 for 5 cycles after out_valid → diff, bo, ovf and out_valid held stable.
  - Pulse start with a=1, b=1 during RUN and DONE → ignored; result unchanged.
  - Result is accepted when out_ready rises.
- Reset mid-operation: assert rst at the 4th RUN edge → next cycle in_ready=1, busy=0, out_valid=0, diff=0. A fresh a=10, b=3 then yields diff=7.
- WIDTH=4 instance, a=3, b=5 → diff=0xE, bo=1, ovf=0, latency 4 cycles.
